// File: rtl/spiker_adapter_reg_pkg.sv
// Register-file view of the spiker adapter as seen by hardware:
// the start control bit and the spike input words.
package spiker_adapter_reg_pkg;

  localparam int unsigned SPIKES_N_REG = 25;
  localparam int unsigned SPIKES_WIDTH = 32;

  typedef struct packed {
    logic q;
    logic qe;
  } spiker_adapter_reg2hw_ctrl_start_t;

  typedef struct packed {
    spiker_adapter_reg2hw_ctrl_start_t start;
  } spiker_adapter_reg2hw_ctrl_reg_t;

  typedef struct packed {
    logic [SPIKES_WIDTH-1:0] q;
  } spiker_adapter_reg2hw_spikes_in_mreg_t;

  typedef struct packed {
    spiker_adapter_reg2hw_ctrl_reg_t                          ctrl;
    spiker_adapter_reg2hw_spikes_in_mreg_t [SPIKES_N_REG-1:0] spikes_in;
  } spiker_adapter_reg2hw_t;

endpackage

// File: rtl/spiker_reader_pkg.sv
// Shared types and default geometry for the spiker input reader.
package spiker_reader_pkg;

  import spiker_adapter_reg_pkg::*;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_N_SPIKES   = 784;
  localparam int unsigned DEF_N_REG      = 25;
  localparam int unsigned DEF_DATA_WIDTH = 800;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_FIRE = 3'd3,
    ST_RUN  = 3'd4
  } reader_state_e;

  function automatic bit size_ok(input int unsigned n_reg, input int unsigned width,
                                 input int unsigned data_width);
    return (n_reg * width) == data_width;
  endfunction

  // Defaults must tile the core bus exactly and agree with the register map.
  localparam bit DEF_SIZE_OK = size_ok(DEF_N_REG, DEF_WIDTH, DEF_DATA_WIDTH)
                               && (DEF_N_REG == SPIKES_N_REG)
                               && (DEF_WIDTH == SPIKES_WIDTH);

endpackage

// File: rtl/spiker_reader.sv
// Copies the software spike registers into a wide buffer, hands it to the
// spiker core with a one-cycle start, and tracks the run until done.
module spiker_reader
  import spiker_adapter_reg_pkg::*;
  import spiker_reader_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned N_SPIKES   = DEF_N_SPIKES,
  parameter int unsigned N_REG      = DEF_N_REG,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   test_mode_i,
  input  spiker_adapter_reg2hw_t reg_file_to_ip,
  output logic [DATA_WIDTH-1:0]  data_in_o,
  output logic                   data_valid_o,
  input  logic                   spiker_ready_i,
  input  logic                   writer_ready_i,
  output logic                   start_o,
  input  logic                   done_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overrun_o
);

  localparam int unsigned CNT_W = $clog2(N_REG);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_REG - 1);
  localparam logic [DATA_WIDTH-1:0] VALID_MASK =
    {{(DATA_WIDTH - N_SPIKES){1'b0}}, {N_SPIKES{1'b1}}};

  if (!size_ok(N_REG, WIDTH, DATA_WIDTH) || !DEF_SIZE_OK) begin : g_size_check
    $error("spiker_reader: N_REG*WIDTH must equal DATA_WIDTH");
  end

  reader_state_e         state_r, state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [DATA_WIDTH-1:0] data_buf_r, buf_s;
  logic                  start_req_s;
  logic                  data_valid_r, start_r, busy_r, done_r, overrun_r;
  logic                  unused_s;

  assign unused_s = test_mode_i;

  // Next-state decode and the buffer image with the current word merged in.
  always_comb begin
    state_s     = state_r;
    start_req_s = reg_file_to_ip.ctrl.start.qe & reg_file_to_ip.ctrl.start.q;
    buf_s       = data_buf_r;
    buf_s[cnt_r*WIDTH +: WIDTH] = reg_file_to_ip.spikes_in[cnt_r].q;
    buf_s       = buf_s & VALID_MASK;
    case (state_r)
      ST_IDLE: if (start_req_s) state_s = ST_LOAD; else state_s = ST_IDLE;
      ST_LOAD: if (cnt_r == CNT_LAST) state_s = ST_ARM; else state_s = ST_LOAD;
      ST_ARM:  if (spiker_ready_i & writer_ready_i) state_s = ST_FIRE; else state_s = ST_ARM;
      ST_FIRE: state_s = ST_RUN;
      ST_RUN:  if (done_i) state_s = ST_IDLE; else state_s = ST_RUN;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, load counter, buffer and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      data_buf_r   <= '0;
      data_valid_r <= 1'b0;
      start_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_IDLE) begin
        cnt_r <= '0;
      end else if (state_r == ST_LOAD) begin
        cnt_r      <= cnt_r + CNT_W'(1);
        data_buf_r <= buf_s;
      end
      // Outputs follow the state being entered so they line up with it.
      data_valid_r <= (state_s == ST_ARM) || (state_s == ST_FIRE) || (state_s == ST_RUN);
      start_r      <= (state_s == ST_FIRE);
      busy_r       <= (state_s != ST_IDLE);
      done_r       <= (state_r == ST_RUN) && done_i;
      if (start_req_s) begin
        overrun_r <= (state_r != ST_IDLE);
      end
    end
  end

  assign data_in_o    = data_buf_r;
  assign data_valid_o = data_valid_r;
  assign start_o      = start_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign overrun_o    = overrun_r;

endmodule

// File: tb/tb_spiker_reader.sv
// Directed/randomized bench for spiker_reader with a bit-level data model
// and a small busy/overrun status model.
module tb_spiker_reader;
  import spiker_adapter_reg_pkg::*;

  localparam int N_REG = 25;
  localparam int WIDTH = 32;
  localparam int N_SPIKES = 784;
  localparam int DATA_WIDTH = 800;

  logic clk = 1'b0;
  logic rst_i, test_mode_i, spiker_ready_i, writer_ready_i, done_i;
  spiker_adapter_reg2hw_t r2h;
  logic [DATA_WIDTH-1:0] data_in_o;
  logic data_valid_o, start_o, busy_o, done_o, overrun_o;

  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] words [N_REG];
  logic m_busy = 1'b0;
  logic m_ov = 1'b0;
  logic [DATA_WIDTH-1:0] held;
  int vlat;

  spiker_reader dut (
    .clk_i(clk), .rst_i(rst_i), .test_mode_i(test_mode_i), .reg_file_to_ip(r2h),
    .data_in_o(data_in_o), .data_valid_o(data_valid_o),
    .spiker_ready_i(spiker_ready_i), .writer_ready_i(writer_ready_i),
    .start_o(start_o), .done_i(done_i), .busy_o(busy_o), .done_o(done_o),
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_WIDTH-1:0] obs,
                       input logic [DATA_WIDTH-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected core bus: bit b is bit (b mod WIDTH) of word (b div WIDTH), zero past N_SPIKES.
  function automatic logic [DATA_WIDTH-1:0] model_vec();
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    for (int b = 0; b < DATA_WIDTH; b++)
      v[b] = (b < N_SPIKES) ? words[b / WIDTH][b % WIDTH] : 1'b0;
    return v;
  endfunction

  task automatic load_regs(input bit rnd);
    for (int i = 0; i < N_REG; i++) begin
      words[i] = rnd ? WIDTH'($urandom) : (32'hA5A50000 | 32'(i));
      r2h.spikes_in[i].q = words[i];
    end
  endtask

  task automatic pulse_start(input logic q_bit, input logic done_bit);
    r2h.ctrl.start.qe = 1'b1;
    r2h.ctrl.start.q  = q_bit;
    done_i = done_bit;
    tick();
    r2h.ctrl.start.qe = 1'b0;
    r2h.ctrl.start.q  = 1'b0;
    done_i = 1'b0;
    if (q_bit) begin
      if (m_busy) m_ov = 1'b1;
      else begin m_ov = 1'b0; m_busy = 1'b1; end
    end
    if (done_bit) m_busy = 1'b0;
  endtask

  // Returns the cycle offset (relative to the start request cycle) at which data_valid_o rose.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      if (data_valid_o === 1'b1) begin lat = n; break; end
      tick();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"}, data_in_o, '0);
    check({tag, "_valid"}, data_valid_o, 1'b0);
    check({tag, "_start"}, start_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_ovr"}, overrun_o, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; test_mode_i = 1'b0; r2h = '0;
    spiker_ready_i = 1'b1; writer_ready_i = 1'b1; done_i = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_i = 1'b0;
    tick();

    // Basic run with the fixed pattern
    load_regs(1'b0);
    pulse_start(1'b1, 1'b0);
    check("basic_busy", busy_o, m_busy);
    check("basic_load_valid", data_valid_o, 1'b0);
    wait_valid(vlat);
    check("basic_valid_lat", 32'(vlat), 32'(N_REG + 1));
    check("basic_arm_start", start_o, 1'b0);
    tick();
    check("basic_start_t27", start_o, 1'b1);
    check("basic_data", data_in_o, model_vec());
    check("basic_pad", {784'd0, data_in_o[DATA_WIDTH-1:N_SPIKES]}, '0);
    tick();
    check("basic_start_once", start_o, 1'b0);
    check("basic_run_valid", data_valid_o, 1'b1);
    repeat (4) tick();
    held = data_in_o;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    m_busy = 1'b0;
    check("basic_done", done_o, 1'b1);
    check("basic_busy_clr", busy_o, m_busy);
    check("basic_hold", data_in_o, held);
    tick();
    check("basic_done_once", done_o, 1'b0);

    // Back-pressure from the writer, with a spurious done while armed
    writer_ready_i = 1'b0;
    load_regs(1'b1);
    pulse_start(1'b1, 1'b0);
    wait_valid(vlat);
    check("bp_valid_lat", 32'(vlat), 32'(N_REG + 1));
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", data_valid_o, 1'b1);
      check("bp_nostart", start_o, 1'b0);
      check("bp_nodone", done_o, 1'b0);
      done_i = (k == 3);
      tick();
    end
    done_i = 1'b0;
    check("bp_busy", busy_o, m_busy);
    writer_ready_i = 1'b1;
    tick();
    check("bp_start", start_o, 1'b1);
    check("bp_data", data_in_o, model_vec());
    tick();

    // Overrun during RUN, then start and done together
    pulse_start(1'b1, 1'b0);
    check("ovr_set", overrun_o, m_ov);
    check("ovr_busy", busy_o, m_busy);
    for (int k = 0; k < 3; k++) begin
      check("ovr_norestart", start_o, 1'b0);
      tick();
    end
    pulse_start(1'b1, 1'b1);
    check("ovr_done", done_o, 1'b1);
    check("ovr_sticky", overrun_o, m_ov);
    check("ovr_busy_clr", busy_o, m_busy);
    tick();
    check("ovr_idle_busy", busy_o, 1'b0);
    check("ovr_idle_valid", data_valid_o, 1'b0);

    // Spurious done in IDLE and an unqualified start strobe
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check("idle_done", done_o, 1'b0);
    check("idle_ovr", overrun_o, m_ov);
    pulse_start(1'b0, 1'b0);
    tick();
    check("qual_busy", busy_o, m_busy);
    check("qual_ovr", overrun_o, m_ov);

    // Accepted start clears overrun; reset in the middle of LOAD
    load_regs(1'b1);
    pulse_start(1'b1, 1'b0);
    check("clr_ovr", overrun_o, m_ov);
    check("clr_busy", busy_o, 1'b1);
    repeat (10) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_busy = 1'b0;
    check_idle_outputs("midrst");
    tick();
    check("midrst_nodone", done_o, 1'b0);

    // Full reload after the abort
    test_mode_i = 1'($urandom);
    load_regs(1'b1);
    pulse_start(1'b1, 1'b0);
    wait_valid(vlat);
    check("reload_valid_lat", 32'(vlat), 32'(N_REG + 1));
    tick();
    check("reload_start", start_o, 1'b1);
    check("reload_data", data_in_o, model_vec());
    repeat (2) tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check("reload_done", done_o, 1'b1);
    check("reload_busy", busy_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spiker_reader.md
Name: spiker_reader

Overview:
- Input-side counterpart of the spiker result path.
- Software writes the input spike vector into N_REG reg-file registers, then pulses a start bit.
- This block copies the registers into a wide buffer (one register per cycle), presents the buffer to the spiker core and fires a one-cycle start once both the core and the result writer are ready.
- It then tracks the run until the core reports done, and exposes busy/done/overrun status.

Parameters:
- WIDTH, 32, width of one spike input register.
- N_SPIKES, 784, number of valid input spike bits.
- N_REG, 25, number of spike input registers; N_REG*WIDTH must equal DATA_WIDTH.
- DATA_WIDTH, 800, width of the spiker core input bus.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- test_mode_i  in  1  scan/test mode; no functional effect.
- reg_file_to_ip  in  spiker_adapter_reg2hw_t  fields used: ctrl.start.q, ctrl.start.qe, spikes_in[N_REG].q.
- data_in_o  out  DATA_WIDTH  buffered spike vector to the core.
- data_valid_o  out  1  data_in_o stable and complete.
- spiker_ready_i  in  1  core idle and able to accept a run.
- writer_ready_i  in  1  result writer free to capture the next result.
- start_o  out  1  one-cycle run start to the core.
- done_i  in  1  core finished the current run (single-cycle pulse).
- busy_o  out  1  high from start acceptance to done.
- done_o  out  1  one-cycle pulse when a run completes.
- overrun_o  out  1  sticky flag: start requested while busy.

Behaviour:
- Reset (rst_i=1 on a clk_i edge):
  - FSM goes to IDLE; the load counter and buffer are cleared.
  - All outputs are 0.
  - Reset asserted mid-run aborts the run silently; no done_o pulse.
- Start acceptance: start_req = start.qe & start.q, sampled only in IDLE.
- States:
  - IDLE: on start_req, clear cnt and overrun_o, go to LOAD, busy_o=1 from the next cycle.
  - LOAD: buf[cnt*WIDTH +: WIDTH] <= spikes_in[cnt].q. Increment cnt. When cnt==N_REG-1, go to ARM.
  - ARM:
    - data_valid_o=1.
    - If spiker_ready_i & writer_ready_i in the same cycle, go to FIRE.
    - Otherwise hold indefinitely (no timeout).
  - FIRE: start_o=1 for exactly this cycle, data_valid_o stays 1, go to RUN.
  - RUN: data_valid_o=1, data_in_o held stable. On done_i: done_o=1 for one cycle, busy_o=0 from the next cycle, go to IDLE.
- Data rules:
  - data_in_o is driven only from the buffer and never changes outside LOAD.
  - Bits [DATA_WIDTH-1:N_SPIKES] are forced to 0, whatever software wrote.
- Latency: start_req in cycle t gives LOAD in cycles t+1..t+N_REG, ARM at t+N_REG+1, and start_o at t+N_REG+2 at the earliest.
- Boundary conditions:
  - start_req in any non-IDLE state is ignored and sets overrun_o. overrun_o is cleared only by the next accepted start.
  - done_i outside RUN is ignored and has no effect on status.
  - done_i in the same cycle as the transition into RUN is not possible (FIRE precedes RUN). done_i during FIRE is ignored.
  - Register writes by software during LOAD affect only registers not yet copied; this is documented, not guarded.
  - start_req and done_i in the same cycle while in RUN: done is processed, the start is ignored and overrun_o is set.
- All outputs are registered; no combinational path from any input to any output.

Decomposition:
- spiker_adapter_reg_pkg holds the reg2hw struct, including the ctrl.start and spikes_in fields.
- Add a spiker_reader_pkg holding the FSM state enum (IDLE, LOAD, ARM, FIRE, RUN) and a compile-time check N_REG*WIDTH==DATA_WIDTH.
- No sub-module; the single FSM plus counter and buffer fits in one module.

Test Plan:
- Basic run:
  - Stimulus: write spikes_in[i]=32'hA5A50000|i, pulse start, hold spiker_ready_i=writer_ready_i=1, pulse done_i 5 cycles after start_o.
  - Required response: start_o exactly at t+27; data_in_o word i equals the written value; bits [799:784] are 0; done_o pulses once; busy_o then 0.
- Back-pressure: hold writer_ready_i=0 for 10 cycles in ARM -> data_valid_o=1 and start_o=0 throughout; start_o fires on the cycle after writer_ready_i rises.
- Overrun: pulse start during RUN -> overrun_o=1, no restart; the next start from IDLE clears overrun_o.
- Reset mid-LOAD: assert rst_i at cnt=10 -> all outputs 0 the next cycle; a later start reloads all 25 words correctly.
- Spurious done: pulse done_i in IDLE and ARM -> no done_o pulse, state unchanged.
- Qualified start: start.qe=1 with start.q=0 -> no start accepted.
